// File: rtl/humandet_pkg.sv
// Shared types and constants for the human-detection video path.
// Boxes use inclusive pixel corners; comparisons are widened by one bit.
package humandet_pkg;

    localparam int COORD_W = 16;

    localparam logic [7:0] DEF_BOX_R = 8'hFF;
    localparam logic [7:0] DEF_BOX_G = 8'h00;
    localparam logic [7:0] DEF_BOX_B = 8'h00;

    typedef struct packed {
        logic [COORD_W-1:0] x_start;
        logic [COORD_W-1:0] y_start;
        logic [COORD_W-1:0] x_end;
        logic [COORD_W-1:0] y_end;
    } bbox_t;

    function automatic logic [COORD_W:0] widen(input logic [COORD_W-1:0] v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/bbox_border_hit.sv
// Combinational test of whether pixel (x, y) lies on the border band of one box.
// Degenerate boxes (end < start) never hit because the inside test fails.
module bbox_border_hit
    import humandet_pkg::*;
#(
    parameter int THICKNESS = 2
) (
    input  bbox_t              i_box,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    output logic               o_hit
);

    localparam int TW = COORD_W + 1;
    localparam logic [TW-1:0] T = TW'(THICKNESS);

    logic [TW-1:0] w_x;
    logic [TW-1:0] w_y;
    logic [TW-1:0] w_xs;
    logic [TW-1:0] w_xe;
    logic [TW-1:0] w_ys;
    logic [TW-1:0] w_ye;
    logic          w_inside;
    logic          w_edge;

    assign w_x  = widen(i_x);
    assign w_y  = widen(i_y);
    assign w_xs = widen(i_box.x_start);
    assign w_xe = widen(i_box.x_end);
    assign w_ys = widen(i_box.y_start);
    assign w_ye = widen(i_box.y_end);

    assign w_inside = (w_xs <= w_x) && (w_x <= w_xe) && (w_ys <= w_y) && (w_y <= w_ye);

    // x > xe-T is written as x+T > xe so a small xe cannot underflow; when
    // xe < T every inside pixel already satisfies x < xs+T anyway.
    assign w_edge = (w_x < w_xs + T) || (w_x + T > w_xe) ||
                    (w_y < w_ys + T) || (w_y + T > w_ye);

    assign o_hit = w_inside && w_edge;

endmodule

// File: rtl/bbox_overlay.sv
// Draws detector boxes as coloured rectangles onto pass-through video.
// Boxes collected during frame N are shown from the first vsync after done.
module bbox_overlay
    import humandet_pkg::*;
#(
    parameter int         IMAGE_WIDTH  = 1280,
    parameter int         IMAGE_HEIGHT = 720,
    parameter int         MAX_BOXES    = 16,
    parameter int         THICKNESS    = 2,
    parameter logic [7:0] BOX_R        = DEF_BOX_R,
    parameter logic [7:0] BOX_G        = DEF_BOX_G,
    parameter logic [7:0] BOX_B        = DEF_BOX_B
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [COORD_W-1:0]                 bbox_x_start,
    input  logic [COORD_W-1:0]                 bbox_y_start,
    input  logic [COORD_W-1:0]                 bbox_x_end,
    input  logic [COORD_W-1:0]                 bbox_y_end,
    input  logic                               bbox_valid,
    input  logic                               done,
    input  logic                               de,
    input  logic                               hsync,
    input  logic                               vsync,
    input  logic [7:0]                         r,
    input  logic [7:0]                         g,
    input  logic [7:0]                         b,
    output logic                               de_out,
    output logic                               hsync_out,
    output logic                               vsync_out,
    output logic [7:0]                         r_out,
    output logic [7:0]                         g_out,
    output logic [7:0]                         b_out,
    output logic [$clog2(MAX_BOXES+1)-1:0]     box_count,
    output logic                               overflow
);

    localparam int CNT_W = $clog2(MAX_BOXES + 1);
    localparam int IDX_W = (MAX_BOXES > 1) ? $clog2(MAX_BOXES) : 1;
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(IMAGE_WIDTH);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(IMAGE_HEIGHT);

    bbox_t              r_bank [2][MAX_BOXES];
    logic               r_bank_sel;
    logic               r_swap_pending;
    logic               r_collect_ovf;
    logic [CNT_W-1:0]   r_collect_cnt;
    logic               r_de_d;
    logic               r_vs_d;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;

    bbox_t              w_new_box;
    logic               w_vs_rise;
    logic               w_de_fall;
    logic               w_swap;
    logic               w_wr_en;
    logic               w_wr_bank;
    logic [IDX_W-1:0]   w_wr_idx;
    logic [MAX_BOXES-1:0] w_hit_vec;
    logic               w_hit;

    assign w_new_box = '{x_start: bbox_x_start, y_start: bbox_y_start,
                         x_end:   bbox_x_end,   y_end:   bbox_y_end};

    assign w_vs_rise = vsync && !r_vs_d;
    assign w_de_fall = !de && r_de_d;
    assign w_swap    = w_vs_rise && r_swap_pending;

    // On the swap cycle the bank being released by the display is the new
    // collect bank, so a coincident box lands at its index 0.
    assign w_wr_bank = w_swap ? r_bank_sel : ~r_bank_sel;
    assign w_wr_idx  = w_swap ? '0 : r_collect_cnt[IDX_W-1:0];
    assign w_wr_en   = bbox_valid && (w_swap || (r_collect_cnt < CNT_W'(MAX_BOXES)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < MAX_BOXES; i++) begin
                    r_bank[k][i] <= '0;
                end
            end
        end else if (w_wr_en) begin
            r_bank[w_wr_bank][w_wr_idx] <= w_new_box;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bank_sel     <= 1'b0;
            r_swap_pending <= 1'b0;
            r_collect_cnt  <= '0;
            r_collect_ovf  <= 1'b0;
            box_count      <= '0;
            overflow       <= 1'b0;
        end else if (w_swap) begin
            r_bank_sel     <= ~r_bank_sel;
            r_swap_pending <= done;
            box_count      <= r_collect_cnt;
            overflow       <= r_collect_ovf;
            r_collect_cnt  <= bbox_valid ? CNT_W'(1) : '0;
            r_collect_ovf  <= 1'b0;
        end else begin
            if (done) begin
                r_swap_pending <= 1'b1;
            end
            if (bbox_valid) begin
                if (w_wr_en) begin
                    r_collect_cnt <= r_collect_cnt + 1'b1;
                end else begin
                    r_collect_ovf <= 1'b1;
                end
            end
        end
    end

    // Counters hold at the image limits so malformed timing cannot wrap them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x    <= '0;
            r_y    <= '0;
            r_de_d <= 1'b0;
            r_vs_d <= 1'b0;
        end else begin
            r_de_d <= de;
            r_vs_d <= vsync;
            if (w_vs_rise) begin
                r_x <= '0;
                r_y <= '0;
            end else if (de) begin
                if (r_x < X_MAX) begin
                    r_x <= r_x + 1'b1;
                end
            end else if (w_de_fall) begin
                r_x <= '0;
                if (r_y < Y_MAX) begin
                    r_y <= r_y + 1'b1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < MAX_BOXES; gi++) begin : g_hit
        logic w_raw;
        bbox_border_hit #(.THICKNESS(THICKNESS)) u_hit (
            .i_box (r_bank[r_bank_sel][gi]),
            .i_x   (r_x),
            .i_y   (r_y),
            .o_hit (w_raw)
        );
        assign w_hit_vec[gi] = w_raw && (CNT_W'(gi) < box_count);
    end

    assign w_hit = |w_hit_vec;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            de_out    <= 1'b0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
            r_out     <= '0;
            g_out     <= '0;
            b_out     <= '0;
        end else begin
            de_out    <= de;
            hsync_out <= hsync;
            vsync_out <= vsync;
            if (de && w_hit) begin
                {r_out, g_out, b_out} <= {BOX_R, BOX_G, BOX_B};
            end else begin
                {r_out, g_out, b_out} <= {r, g, b};
            end
        end
    end

endmodule

// File: doc/bbox_overlay.md
# bbox_overlay

Consumes bounding boxes from the human-detection pipeline and draws them as coloured rectangles onto the pass-through video stream. Sits directly downstream of the detector: detector bbox/done outputs and video outputs feed this block, whose video outputs go to the HDMI/VGA output path. Boxes from frame N are collected while frame N is displayed. They are shown from the next frame start after `done`, using a double-buffered box store.

## Interface
- `IMAGE_WIDTH`, 1280, active pixels per line
- `IMAGE_HEIGHT`, 720, active lines per frame
- `MAX_BOXES`, 16, box capacity per bank
- `THICKNESS`, 2, border width in pixels (≥1)
- `BOX_R` / `BOX_G` / `BOX_B`, 8'hFF / 8'h00 / 8'h00, border colour
- `clk`  in  1  pixel clock
- `reset`  in  1  asynchronous, active-low reset
- `bbox_x_start`, `bbox_y_start`, `bbox_x_end`, `bbox_y_end`  in  16 each  inclusive box corners, pixel units
- `bbox_valid`  in  1  one-cycle strobe, box fields valid
- `done`  in  1  one-cycle strobe, detector finished current frame
- `de`, `hsync`, `vsync`  in  1 each  video timing; `vsync` active-high
- `r`, `g`, `b`  in  8 each  pixel
- `de_out`, `hsync_out`, `vsync_out`  out  1 each  timing delayed 1 cycle
- `r_out`, `g_out`, `b_out`  out  8 each  overlaid pixel
- `box_count`  out  $clog2(MAX_BOXES+1)  boxes in display bank
- `overflow`  out  1  sticky per collected frame; a box was dropped

## Operation
- Two banks of `MAX_BOXES` entries plus per-bank count. `bank_sel` selects the display bank; the other bank collects.
- Collect: on `bbox_valid`, if `collect_cnt < MAX_BOXES`, write the box at index `collect_cnt` and increment the count. Otherwise drop the box and set `collect_ovf`.
- `done` sets `swap_pending`.
- On the `vsync` rising edge with `swap_pending`=1:
  - toggle `bank_sel`, clear `swap_pending`
  - `box_count` ← old `collect_cnt`; `overflow` ← old `collect_ovf`
  - new `collect_cnt` ← 0, `collect_ovf` ← 0
- On the `vsync` rising edge without `swap_pending`: no swap. The display bank is kept and the collect bank keeps accumulating.
- Simultaneous events:
  - `bbox_valid` and `done` in the same cycle: box is stored first, then pending set.
  - `bbox_valid` on the swap cycle: box goes to index 0 of the newly freed collect bank.
  - `done` on the swap cycle: re-arms `swap_pending` after the clear.
- Pixel position counters:
  - `x` increments on each `de` cycle and resets to 0 on the `de` falling edge.
  - `y` increments on the `de` falling edge.
  - Both reset on the `vsync` rising edge.
- Border hit for display entry i (i < `box_count`), all conditions required:
  - `xs ≤ x ≤ xe` and `ys ≤ y ≤ ye`
  - and one of: `x < xs+T`, `x > xe−T`, `y < ys+T`, `y > ye−T`
  - Comparisons are 17-bit unsigned so `xs+T` cannot wrap.
  - `xe < xs` or `ye < ys`: entry never hits.
- Output pixel = border colour if `de` and any entry hits, else input pixel. Never modified when `de`=0.
- Reset values: all outputs 0, both counts 0, `bank_sel`=0, `swap_pending`=0, `overflow`=0.
- Reset asserted mid-frame clears state immediately. Output resumes pass-through one cycle after release; first overlay appears after the next `done`→`vsync` sequence.

## Timing
- Fixed 1-cycle latency on all video outputs; hit logic and mux are registered together.
- Bank swap is visible from the first pixel of the frame following the `vsync` edge.
- No backpressure: `bbox_valid` is accepted every cycle, including back-to-back.
- `box_count` and `overflow` update in the cycle after the swapping `vsync` edge.

## Structure
- Package `humandet_pkg`: `bbox_t` struct (4×16-bit corners), `COORD_W`=16, default colour constants.
- Sub-module `bbox_border_hit`: combinational, one `bbox_t` + `x`, `y`, `THICKNESS` → hit. Generate-instanced `MAX_BOXES` times on the display bank, results OR-reduced.
- Box banks are flop arrays; a frame rate of ≤16 writes needs no RAM.

## Test plan
- Reset: hold `reset`=0 mid-line → all outputs 0. Release → `r_out`=`r` one cycle later; `box_count`=0.
- Single box (100,50)-(163,177), `done`, `vsync`:
  - next frame, pixel (100,60) and (131,50) → FF/00/00
  - (131,60) and (102,60) → input pixel (T=2)
  - (99,60) → input pixel
- 18 boxes then `done`, `vsync` → `box_count`=16, `overflow`=1. Next frame without new overflow → `overflow`=0.
- No `done` before `vsync` → previous boxes still drawn; new boxes accumulate and appear after a later `done`.
- `bbox_valid`+`done` same cycle, and `bbox_valid` on the swap cycle → first box displayed next frame; second box held at collect index 0.
- Degenerate box xs=200, xe=150 → no pixel changed; `de`=0 blanking pixels unchanged over a box edge.
